// File: rtl/tcm_port_arb.sv
// Two-port (core pipeline + AHB) arbiter and SRAM front-end for one TCM bank.
// Optional fair arbitration with an AHB starvation counter: define KRV_TCM_FAIR_ARB_EN.
module tcm_port_arb #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          AW           = 12,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          core_req,
    input  logic [31:0]   core_addr,
    input  logic          core_wr1_rd0,
    input  logic [3:0]    core_byte_strobe,
    input  logic [31:0]   core_wdata,
    output logic          core_gnt,
    output logic [31:0]   core_rdata,
    output logic          core_rdata_valid,
    input  logic          AHB_tcm_access,
    input  logic [31:0]   AHB_tcm_addr,
    input  logic          AHB_tcm_rd0_wr1,
    input  logic [3:0]    AHB_tcm_byte_strobe,
    input  logic [31:0]   AHB_tcm_write_data,
    output logic [31:0]   AHB_tcm_read_data,
    output logic          AHB_tcm_read_data_valid,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [3:0]    sram_be,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [3:0]    pend_be_q, pend_be_d;
    logic          pend_we_q, pend_we_d;
    logic [31:0]   pend_wdata_q, pend_wdata_d;
    logic [1:0]    tag_q, tag_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;

    logic [31:0]   core_off_s, ahb_off_s;
    logic [AW-1:0] core_waddr_s, live_waddr_s;
    logic          ahb_live_s, ahb_src_s, force_ahb_s, core_win_s, ahb_win_s;
    logic [AW-1:0] ahb_waddr_s;
    logic [3:0]    ahb_be_s;
    logic          ahb_we_s;
    logic [31:0]   ahb_wdata_s;
    logic          unused_bits_s;

    assign core_off_s   = core_addr - BASE_ADDR;
    assign ahb_off_s    = AHB_tcm_addr - BASE_ADDR;
    assign core_waddr_s = core_off_s[AW+1:2];
    assign live_waddr_s = ahb_off_s[AW+1:2];

    // A live pulse is ignored while a pending entry exists; pending always wins the AHB side.
    assign ahb_live_s  = AHB_tcm_access && !pend_valid_q;
    assign ahb_src_s   = pend_valid_q || ahb_live_s;
    assign ahb_waddr_s = pend_valid_q ? pend_addr_q  : live_waddr_s;
    assign ahb_be_s    = pend_valid_q ? pend_be_q    : AHB_tcm_byte_strobe;
    assign ahb_we_s    = pend_valid_q ? pend_we_q    : AHB_tcm_rd0_wr1;
    assign ahb_wdata_s = pend_valid_q ? pend_wdata_q : AHB_tcm_write_data;

`ifdef KRV_TCM_FAIR_ARB_EN
    assign force_ahb_s   = pend_valid_q && (starve_cnt_q >= 4'(STARVE_LIMIT));
    assign unused_bits_s = ^{core_off_s[31:AW+2], core_off_s[1:0],
                             ahb_off_s[31:AW+2], ahb_off_s[1:0]};
`else
    assign force_ahb_s   = 1'b0;
    assign unused_bits_s = ^{core_off_s[31:AW+2], core_off_s[1:0],
                             ahb_off_s[31:AW+2], ahb_off_s[1:0],
                             starve_cnt_q, 4'(STARVE_LIMIT)};
`endif

    assign core_win_s = core_req && !force_ahb_s;
    assign ahb_win_s  = ahb_src_s && !core_win_s;
    assign core_gnt   = core_win_s;

    assign core_rdata              = sram_rdata;
    assign AHB_tcm_read_data       = sram_rdata;
    assign core_rdata_valid        = (tag_q == 2'b01);
    assign AHB_tcm_read_data_valid = tag_q[1];

    // SRAM port mux: reads always use a full byte mask.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_be    = 4'h0;
        sram_wdata = 32'h0;
        if (core_win_s) begin
            sram_cs    = 1'b1;
            sram_we    = core_wr1_rd0;
            sram_addr  = core_waddr_s;
            sram_be    = core_wr1_rd0 ? core_byte_strobe : 4'hF;
            sram_wdata = core_wr1_rd0 ? core_wdata : 32'h0;
        end else if (ahb_win_s) begin
            sram_cs    = 1'b1;
            sram_we    = ahb_we_s;
            sram_addr  = ahb_waddr_s;
            sram_be    = ahb_we_s ? ahb_be_s : 4'hF;
            sram_wdata = ahb_we_s ? ahb_wdata_s : 32'h0;
        end else begin
            sram_cs    = 1'b0;
        end
    end

    // Next-state for holding register, response tag and starvation counter.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_be_d    = pend_be_q;
        pend_we_d    = pend_we_q;
        pend_wdata_d = pend_wdata_q;
        starve_cnt_d = starve_cnt_q;
        tag_d        = 2'b00;

        if (ahb_live_s && !ahb_win_s) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = live_waddr_s;
            pend_be_d    = AHB_tcm_byte_strobe;
            pend_we_d    = AHB_tcm_rd0_wr1;
            pend_wdata_d = AHB_tcm_write_data;
        end else if (pend_valid_q && ahb_win_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        if (core_win_s) begin
            tag_d = {1'b0, !core_wr1_rd0};
        end else if (ahb_win_s) begin
            tag_d = {1'b1, !ahb_we_s};
        end else begin
            tag_d = 2'b00;
        end

`ifdef KRV_TCM_FAIR_ARB_EN
        if (ahb_win_s) begin
            starve_cnt_d = 4'd0;
        end else if (pend_valid_q && core_win_s) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
`else
        starve_cnt_d = 4'd0;
`endif
    end

    // State registers; reset drops any pending entry and outstanding strobe.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_be_q    <= 4'h0;
            pend_we_q    <= 1'b0;
            pend_wdata_q <= 32'h0;
            tag_q        <= 2'b00;
            starve_cnt_q <= 4'd0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_be_q    <= pend_be_d;
            pend_we_q    <= pend_we_d;
            pend_wdata_q <= pend_wdata_d;
            tag_q        <= tag_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed self-checking bench for tcm_port_arb with a byte-writable SRAM model.
module tb_tcm_port_arb;
    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          core_req, core_wr1_rd0;
    logic [31:0]   core_addr, core_wdata;
    logic [3:0]    core_byte_strobe;
    logic          core_gnt, core_rdata_valid;
    logic [31:0]   core_rdata;
    logic          AHB_tcm_access, AHB_tcm_rd0_wr1;
    logic [31:0]   AHB_tcm_addr, AHB_tcm_write_data, AHB_tcm_read_data;
    logic [3:0]    AHB_tcm_byte_strobe;
    logic          AHB_tcm_read_data_valid;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata, sram_rdata;

    logic [31:0] mem [0:(1<<AW)-1];
    int n_vec = 0;
    int n_err = 0;

    tcm_port_arb #(.BASE_ADDR(32'h0000_0000), .AW(AW), .STARVE_LIMIT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .core_req(core_req), .core_addr(core_addr), .core_wr1_rd0(core_wr1_rd0),
        .core_byte_strobe(core_byte_strobe), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rdata_valid(core_rdata_valid),
        .AHB_tcm_access(AHB_tcm_access), .AHB_tcm_addr(AHB_tcm_addr),
        .AHB_tcm_rd0_wr1(AHB_tcm_rd0_wr1), .AHB_tcm_byte_strobe(AHB_tcm_byte_strobe),
        .AHB_tcm_write_data(AHB_tcm_write_data), .AHB_tcm_read_data(AHB_tcm_read_data),
        .AHB_tcm_read_data_valid(AHB_tcm_read_data_valid),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 HCLK = ~HCLK;

    // One-cycle-latency single-port SRAM with byte enables.
    always @(posedge HCLK) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle();
        core_req = 1'b0; core_addr = 32'h0; core_wr1_rd0 = 1'b0;
        core_byte_strobe = 4'h0; core_wdata = 32'h0;
        AHB_tcm_access = 1'b0; AHB_tcm_addr = 32'h0; AHB_tcm_rd0_wr1 = 1'b0;
        AHB_tcm_byte_strobe = 4'h0; AHB_tcm_write_data = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEAD_BEEF;
        mem[9]  = 32'hFFFF_FFFF;
        mem[2]  = 32'hA5A5_0002;
        mem[3]  = 32'h3333_3333;
        sram_rdata = 32'h0;
        idle();
        HRESETn = 1'b0;
        step(); step();
        chk("rst_core_valid", {31'h0, core_rdata_valid}, 32'd0);
        chk("rst_ahb_valid", {31'h0, AHB_tcm_read_data_valid}, 32'd0);
        chk("rst_cs", {31'h0, sram_cs}, 32'd0);
        chk("rst_gnt", {31'h0, core_gnt}, 32'd0);
        HRESETn = 1'b1;
        step();

        // Core read of 0x10
        core_req = 1'b1; core_addr = 32'h0000_0010; #1;
        chk("crd_gnt", {31'h0, core_gnt}, 32'd1);
        chk("crd_cs", {31'h0, sram_cs}, 32'd1);
        chk("crd_we", {31'h0, sram_we}, 32'd0);
        chk("crd_addr", {20'h0, sram_addr}, 32'd4);
        chk("crd_be", {28'h0, sram_be}, 32'hF);
        step(); idle(); #1;
        chk("crd_valid", {31'h0, core_rdata_valid}, 32'd1);
        chk("crd_data", core_rdata, 32'hDEAD_BEEF);
        chk("crd_no_ahb_valid", {31'h0, AHB_tcm_read_data_valid}, 32'd0);
        // Low and out-of-bank address bits are ignored
        core_req = 1'b1; core_addr = 32'h0001_0013; #1;
        chk("crd_addr_trunc", {20'h0, sram_addr}, 32'd4);
        step(); idle(); #1;
        chk("crd_idle_cs", {31'h0, sram_cs}, 32'd0);

        // Uncontended AHB write
        AHB_tcm_access = 1'b1; AHB_tcm_rd0_wr1 = 1'b1; AHB_tcm_addr = 32'h24;
        AHB_tcm_byte_strobe = 4'b0011; AHB_tcm_write_data = 32'h1234_5678; #1;
        chk("awr_cs", {31'h0, sram_cs}, 32'd1);
        chk("awr_we", {31'h0, sram_we}, 32'd1);
        chk("awr_addr", {20'h0, sram_addr}, 32'd9);
        chk("awr_be", {28'h0, sram_be}, 32'h3);
        chk("awr_wdata", sram_wdata, 32'h1234_5678);
        chk("awr_gnt", {31'h0, core_gnt}, 32'd0);
        step(); idle(); #1;
        chk("awr_valid", {31'h0, AHB_tcm_read_data_valid}, 32'd1);
        chk("awr_no_core_valid", {31'h0, core_rdata_valid}, 32'd0);
        core_req = 1'b1; core_addr = 32'h24; #1;
        step(); idle(); #1;
        chk("awr_merge", core_rdata, 32'hFFFF_5678);

        // Contended AHB read: core held, AHB pulse to 0x8
        core_req = 1'b1; core_addr = 32'h40;
        AHB_tcm_access = 1'b1; AHB_tcm_rd0_wr1 = 1'b0; AHB_tcm_addr = 32'h8; #1;
        chk("cont_gnt0", {31'h0, core_gnt}, 32'd1);
        chk("cont_addr0", {20'h0, sram_addr}, 32'd16);
        step(); AHB_tcm_access = 1'b0; #1;
        chk("cont_gnt1", {31'h0, core_gnt}, 32'd1);
        chk("cont_no_ahb_valid1", {31'h0, AHB_tcm_read_data_valid}, 32'd0);
        step(); core_req = 1'b0; #1;
        chk("cont_cs2", {31'h0, sram_cs}, 32'd1);
        chk("cont_addr2", {20'h0, sram_addr}, 32'd2);
        chk("cont_we2", {31'h0, sram_we}, 32'd0);
        chk("cont_no_ahb_valid2", {31'h0, AHB_tcm_read_data_valid}, 32'd0);
        step(); #1;
        chk("cont_valid3", {31'h0, AHB_tcm_read_data_valid}, 32'd1);
        chk("cont_data3", AHB_tcm_read_data, 32'hA5A5_0002);
        chk("cont_cs3", {31'h0, sram_cs}, 32'd0);
        step(); idle();

        // Long core burst with a pending AHB read of 0xC
        core_req = 1'b1; core_addr = 32'h44;
        AHB_tcm_access = 1'b1; AHB_tcm_rd0_wr1 = 1'b0; AHB_tcm_addr = 32'hC; #1;
        chk("starve_gnt0", {31'h0, core_gnt}, 32'd1);
`ifdef KRV_TCM_FAIR_ARB_EN
        for (int k = 1; k <= 4; k++) begin
            step(); AHB_tcm_access = 1'b0; #1;
            chk("fair_lost_gnt", {31'h0, core_gnt}, 32'd1);
        end
        step(); #1;
        chk("fair_force_gnt", {31'h0, core_gnt}, 32'd0);
        chk("fair_force_addr", {20'h0, sram_addr}, 32'd3);
        step(); #1;
        chk("fair_resume_gnt", {31'h0, core_gnt}, 32'd1);
        chk("fair_valid", {31'h0, AHB_tcm_read_data_valid}, 32'd1);
        chk("fair_data", AHB_tcm_read_data, 32'h3333_3333);
        step(); #1;
        chk("fair_single_valid", {31'h0, AHB_tcm_read_data_valid}, 32'd0);
        chk("fair_gnt_again", {31'h0, core_gnt}, 32'd1);
        idle();
`else
        for (int k = 1; k <= 8; k++) begin
            step(); AHB_tcm_access = 1'b0; #1;
            chk("strict_gnt", {31'h0, core_gnt}, 32'd1);
            chk("strict_no_valid", {31'h0, AHB_tcm_read_data_valid}, 32'd0);
        end
        step(); core_req = 1'b0; #1;
        chk("strict_issue_addr", {20'h0, sram_addr}, 32'd3);
        chk("strict_issue_cs", {31'h0, sram_cs}, 32'd1);
        step(); #1;
        chk("strict_valid", {31'h0, AHB_tcm_read_data_valid}, 32'd1);
        chk("strict_data", AHB_tcm_read_data, 32'h3333_3333);
`endif
        step(); idle(); step();

        // Reset with a pending AHB entry and an outstanding core read
        core_req = 1'b1; core_addr = 32'h0;
        AHB_tcm_access = 1'b1; AHB_tcm_rd0_wr1 = 1'b1; AHB_tcm_addr = 32'h30;
        AHB_tcm_byte_strobe = 4'hF; AHB_tcm_write_data = 32'h7777_7777; #1;
        chk("rstp_gnt", {31'h0, core_gnt}, 32'd1);
        step(); idle(); HRESETn = 1'b0; #1;
        chk("rstp_cs_in_rst", {31'h0, sram_cs}, 32'd0);
        chk("rstp_core_valid_lost", {31'h0, core_rdata_valid}, 32'd0);
        step(); HRESETn = 1'b1; #1;
        chk("rstp_cs_after", {31'h0, sram_cs}, 32'd0);
        step(); #1;
        chk("rstp_no_ahb_valid", {31'h0, AHB_tcm_read_data_valid}, 32'd0);
        chk("rstp_cs_after2", {31'h0, sram_cs}, 32'd0);
        chk("rstp_mem_untouched", mem[12], 32'h0);

        // Core write then read of the same word
        core_req = 1'b1; core_addr = 32'h50; core_wr1_rd0 = 1'b1;
        core_byte_strobe = 4'hF; core_wdata = 32'hCAFE_F00D; #1;
        chk("cwr_gnt", {31'h0, core_gnt}, 32'd1);
        chk("cwr_we", {31'h0, sram_we}, 32'd1);
        step(); core_wr1_rd0 = 1'b0; core_wdata = 32'h0; #1;
        chk("cwr_no_valid", {31'h0, core_rdata_valid}, 32'd0);
        chk("cwr_rd_gnt", {31'h0, core_gnt}, 32'd1);
        step(); idle(); #1;
        chk("cwr_rd_valid", {31'h0, core_rdata_valid}, 32'd1);
        chk("cwr_rd_data", core_rdata, 32'hCAFE_F00D);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
